// File: rtl/icache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDR_W    = 10;
    localparam int INDEX_W   = 3;
    localparam int TAG_W     = 3;
    localparam int OFFSET_W  = 2;
    localparam int BLKADDR_W = 6;
    localparam int BLOCK_W   = 128;
    localparam int WORD_W    = 32;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    function automatic logic [OFFSET_W-1:0] pc_offset(input logic [ADDR_W-1:0] pc);
        return pc[3:2];
    endfunction

    function automatic logic [INDEX_W-1:0] pc_index(input logic [ADDR_W-1:0] pc);
        return pc[6:4];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [ADDR_W-1:0] pc);
        return pc[9:7];
    endfunction

    function automatic logic [BLKADDR_W-1:0] pc_block(input logic [ADDR_W-1:0] pc);
        return pc[9:4];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the cache lines: combinational read by index, synchronous fill.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [BLOCK_W-1:0] o_rd_data,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [BLOCK_W-1:0] i_wr_data
);

    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [BLOCK_W-1:0] r_data [LINES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays have no reset; a line is only ever used when its
    // valid bit is set, so clearing the valid bits alone is enough.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: hit path, miss/refill FSM and saturating hit/miss counters.
module icache_controller
    import icache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int PC_W  = 10
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 read,
    input  logic [PC_W-1:0]      pc,
    output logic [WORD_W-1:0]    instruction,
    output logic                 busywait,
    output logic                 mem_read,
    output logic [BLKADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]   mem_readinst,
    input  logic                 mem_busywait,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);

    state_t               r_state;
    state_t               w_next_state;
    logic [BLKADDR_W-1:0] r_miss_block;
    logic [CNT_W-1:0]     r_hit_count;
    logic [CNT_W-1:0]     r_miss_count;

    logic                 w_line_valid;
    logic [TAG_W-1:0]     w_line_tag;
    logic [BLOCK_W-1:0]   w_line_data;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_fill;

    icache_line_array #(.LINES(LINES)) u_lines (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_rd_index (pc_index(pc)),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_fill),
        .i_wr_index (r_miss_block[INDEX_W-1:0]),
        .i_wr_tag   (r_miss_block[BLKADDR_W-1:INDEX_W]),
        .i_wr_data  (mem_readinst)
    );

    assign w_hit       = read && w_line_valid && (w_line_tag == pc_tag(pc));
    assign w_miss      = read && !w_hit;
    assign w_fill      = (r_state == UPDATE);
    assign instruction = w_line_data[pc_offset(pc)*WORD_W +: WORD_W];
    assign mem_address = r_miss_block;
    assign hit_count   = r_hit_count;
    assign miss_count  = r_miss_count;

    // NOTE: every output of this block gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        busywait     = 1'b0;
        mem_read     = 1'b0;
        unique case (r_state)
            IDLE: begin
                busywait = w_miss;
                if (w_miss) w_next_state = MEM_READ;
            end
            MEM_READ: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) w_next_state = UPDATE;
            end
            UPDATE: begin
                busywait     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_miss_block <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_miss) begin
                r_miss_block <= pc_block(pc);
                if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
            end
            if (r_state == IDLE && w_hit && r_hit_count != '1) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
        end
    end

endmodule
